// File: rtl/hp_queue.sv
// ============================================================================
// Module   : hp_queue
// Brief    : Circular sample queue that streams its DEPTH most recent samples,
//            oldest first, after every accepted write once the queue is full.
//            Optional sticky overrun flag when HP_QUEUE_OVR_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hp_queue #(
   parameter int DEPTH = 1021
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wrt_smpl,
   input  logic signed [15:0] smpl_in,
   output logic               sequencing,
   output logic signed [15:0] smpl_out
`ifdef HP_QUEUE_OVR_EN
   ,
   output logic               ovr
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [9:0] LAST = 10'(DEPTH - 1);
   localparam logic [9:0] FULL = 10'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      SEQ   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic signed [15:0] mem [DEPTH];

   logic [9:0] new_ptr;
   logic [9:0] old_ptr;
   logic [9:0] rd_ptr;
   logic [9:0] cnt;
   logic [9:0] seq_cnt;

   logic       wr_acc;
   logic       rd_en;
   logic [9:0] rd_addr;

   function automatic logic [9:0] ptr_inc(input logic [9:0] p);
      return (p == LAST) ? 10'd0 : p + 10'd1;
   endfunction

   assign wr_acc     = wrt_smpl && (state == IDLE);
   assign sequencing = (state == SEQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // PRIME issues the first read; SEQ issues the remaining DEPTH-1 reads.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_addr   = rd_ptr;
      case (state)
         IDLE: begin
            if (wr_acc && ((cnt == FULL) || (cnt == LAST))) begin
               state_nxt = PRIME;
            end
         end
         PRIME: begin
            rd_en     = 1'b1;
            rd_addr   = old_ptr;
            state_nxt = SEQ;
         end
         SEQ: begin
            rd_en = (seq_cnt < LAST);
            if (seq_cnt == LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         new_ptr <= '0;
         old_ptr <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         seq_cnt <= '0;
      end else begin
         if (wr_acc) begin
            new_ptr <= ptr_inc(new_ptr);
            if (cnt == FULL) begin
               old_ptr <= ptr_inc(old_ptr);
            end else begin
               cnt <= cnt + 10'd1;
            end
         end
         if (state == PRIME) begin
            rd_ptr  <= ptr_inc(old_ptr);
            seq_cnt <= '0;
         end else if (state == SEQ) begin
            seq_cnt <= seq_cnt + 10'd1;
            if (rd_en) begin
               rd_ptr <= ptr_inc(rd_ptr);
            end
         end
      end
   end

   // Storage array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[new_ptr[AW-1:0]] <= smpl_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smpl_out <= '0;
      end else if (rd_en) begin
         smpl_out <= mem[rd_addr[AW-1:0]];
      end
   end

`ifdef HP_QUEUE_OVR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr <= 1'b0;
      end else if (wrt_smpl && (state != IDLE)) begin
         ovr <= 1'b1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hp_queue.sv
// ============================================================================
// Module   : tb_hp_queue
// Brief    : Scoreboard bench for hp_queue (DEPTH=4 and default DEPTH).
//            Checks ovr when HP_QUEUE_OVR_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hp_queue;

   typedef struct {
      int v;
      int c;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               wrt4, wrtb;
   logic signed [15:0] smpl4, smplb;
   logic               seq4, seqb;
   logic signed [15:0] out4, outb;
`ifdef HP_QUEUE_OVR_EN
   logic               ovr4, ovrb;
`endif

   int   cyc;
   int   checks;
   int   failures;
   exp_t sb4[$];
   exp_t sbb[$];

   hp_queue #(.DEPTH(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt_smpl   (wrt4),
      .smpl_in    (smpl4),
      .sequencing (seq4),
      .smpl_out   (out4)
`ifdef HP_QUEUE_OVR_EN
      ,
      .ovr        (ovr4)
`endif
   );

   hp_queue dutb (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt_smpl   (wrtb),
      .smpl_in    (smplb),
      .sequencing (seqb),
      .smpl_out   (outb)
`ifdef HP_QUEUE_OVR_EN
      ,
      .ovr        (ovrb)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every sequencing cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (sb4.size() > 0 && sb4[0].c < cyc) begin
         checks++; failures++;
         e = sb4.pop_front();
         $display("FAIL d4_missing_sample cyc=%0d got=no_sequencing exp=%0d@%0d", cyc, e.v, e.c);
      end
      if (seq4) begin
         checks++;
         if (sb4.size() == 0) begin
            failures++;
            $display("FAIL d4_unexpected_sample cyc=%0d got=%0d exp=none", cyc, out4);
         end else begin
            e = sb4.pop_front();
            if (int'(out4) != e.v || cyc != e.c) begin
               failures++;
               $display("FAIL d4_stream got=%0d@%0d exp=%0d@%0d", out4, cyc, e.v, e.c);
            end
         end
      end
      if (sbb.size() > 0 && sbb[0].c < cyc) begin
         checks++; failures++;
         e = sbb.pop_front();
         $display("FAIL dbig_missing_sample cyc=%0d got=no_sequencing exp=%0d@%0d", cyc, e.v, e.c);
      end
      if (seqb) begin
         checks++;
         if (sbb.size() == 0) begin
            failures++;
            $display("FAIL dbig_unexpected_sample cyc=%0d got=%0d exp=none", cyc, outb);
         end else begin
            e = sbb.pop_front();
            if (int'(outb) != e.v || cyc != e.c) begin
               failures++;
               $display("FAIL dbig_stream got=%0d@%0d exp=%0d@%0d", outb, cyc, e.v, e.c);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one write pulse in the current cycle; when a stream is expected,
   // it occupies cycles cyc+2 .. cyc+5.
   task automatic wr4(input int v, input bit stream, input int e0, input int e1,
                      input int e2, input int e3);
      if (stream) begin
         sb4.push_back('{v: e0, c: cyc + 2});
         sb4.push_back('{v: e1, c: cyc + 3});
         sb4.push_back('{v: e2, c: cyc + 4});
         sb4.push_back('{v: e3, c: cyc + 5});
      end
      smpl4 = 16'(v);
      wrt4  = 1'b1;
      wait_cyc(1);
      wrt4  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout got=%0d exp=finished", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      cyc      = 0;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      wrt4     = 1'b0;
      wrtb     = 1'b0;
      smpl4    = '0;
      smplb    = '0;
      #1;
      check("reset_seq4", int'(seq4), 0);
      check("reset_out4", int'(out4), 0);
      check("reset_seqb", int'(seqb), 0);
      check("reset_outb", int'(outb), 0);
`ifdef HP_QUEUE_OVR_EN
      check("reset_ovr4", int'(ovr4), 0);
`endif
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(2);

      // Fill: nothing streams until the 4th write.
      wr4(10, 0, 0, 0, 0, 0);  wait_cyc(9);
      wr4(20, 0, 0, 0, 0, 0);  wait_cyc(9);
      wr4(30, 0, 0, 0, 0, 0);  wait_cyc(9);
      check("fill_no_early_stream", sb4.size(), 0);
      wr4(40, 1, 10, 20, 30, 40);  wait_cyc(9);
      check("fill_stream_done", sb4.size(), 0);

      // Overwrite, with a dropped write in the 2nd sequencing cycle.
`ifdef HP_QUEUE_OVR_EN
      check("ovr_before_drop", int'(ovr4), 0);
`endif
      wr4(50, 1, 20, 30, 40, 50);
      wait_cyc(2);
      wr4(99, 0, 0, 0, 0, 0);
`ifdef HP_QUEUE_OVR_EN
      check("ovr_after_drop", int'(ovr4), 1);
`endif
      wait_cyc(9);
      check("overwrite_stream_done", sb4.size(), 0);
      wr4(60, 1, 30, 40, 50, 60);  wait_cyc(9);
      check("drop_stream_done", sb4.size(), 0);

      // Reset in the 3rd sequencing cycle aborts the stream.
      wr4(70, 1, 40, 50, 60, 70);
      wait_cyc(3);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_seq4", int'(seq4), 0);
      check("abort_out4", int'(out4), 0);
`ifdef HP_QUEUE_OVR_EN
      check("abort_ovr4", int'(ovr4), 0);
`endif
      check("abort_remaining_exp", sb4.size(), 1);
      sb4.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_cyc(2);

      // Restart empty, then wrap the pointers twice with 1..9.
      for (int i = 1; i <= 9; i++) begin
         if (i < 4) wr4(i, 0, 0, 0, 0, 0);
         else       wr4(i, 1, i - 3, i - 2, i - 1, i);
         wait_cyc(9);
         if (i == 3) check("restart_no_stream", sb4.size(), 0);
      end
      check("wrap_stream_done", sb4.size(), 0);
      check("wrap_seq_idle", int'(seq4), 0);
      check("hold_out4", int'(out4), 9);

      // Default depth: ramp 0..1020 written back to back.
      for (int v = 0; v < 1021; v++) begin
         if (v == 1020) begin
            for (int k = 0; k < 1021; k++) sbb.push_back('{v: k, c: cyc + 2 + k});
         end
         smplb = 16'(v);
         wrtb  = 1'b1;
         wait_cyc(1);
      end
      wrtb = 1'b0;
      wait_cyc(1030);
      check("big_stream_done", sbb.size(), 0);
      check("hold_outb", int'(outb), 1020);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hp_queue.md
HP_QUEUE -- requirements
Module: hp_queue

Interface
REQ-001 Parameter DEPTH, default 1021, is the number of samples held and the number of samples streamed per sequence (legal 2..1023).
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 wrt_smpl  input  1  single-cycle pulse meaning a new sample is present on smpl_in.
REQ-005 smpl_in  input  16  signed new sample.
REQ-006 sequencing  output  1  high while smpl_out carries a valid sample of the current stream.
REQ-007 smpl_out  output  16  signed sample stream, oldest first, to the FIR core's smpl_in.
REQ-008 ovr  output  1  sticky flag for a dropped write; present only when HP_QUEUE_OVR_EN is defined.

Function
REQ-009 Storage SHALL be an internal DEPTH x 16 circular array with a synchronous read and 1-cycle read latency; contents are not reset.
REQ-010 Pointers new_ptr, old_ptr and rd_ptr SHALL be 10 bits and SHALL wrap from DEPTH-1 to 0.
REQ-011 Fill count cnt SHALL saturate at DEPTH.
REQ-012 States: IDLE, PRIME, SEQ.
REQ-013 A write SHALL be accepted only when state==IDLE: smpl_in goes to mem[new_ptr], new_ptr increments, and cnt increments if cnt<DEPTH.
REQ-014 If cnt==DEPTH when a write is accepted, the write SHALL overwrite the oldest entry and old_ptr SHALL increment.
REQ-015 A write accepted in cycle n that leaves cnt==DEPTH SHALL move IDLE->PRIME; otherwise the state SHALL stay IDLE.
REQ-016 PRIME (one cycle): the read address is old_ptr after the update from cycle n, rd_ptr is loaded with that value plus 1 (with wrap), and the state moves to SEQ.
REQ-017 SEQ: sequencing=1 for exactly DEPTH consecutive cycles, n+2 through n+DEPTH+1.
REQ-018 In SEQ, smpl_out in the k-th sequencing cycle (k=0..DEPTH-1) SHALL equal the sample at old_ptr+k modulo DEPTH, so the newest sample comes last.
REQ-019 In SEQ, one read SHALL be issued per cycle until DEPTH reads are issued; after the final sequencing cycle the state SHALL return to IDLE.
REQ-020 wrt_smpl in PRIME or SEQ, including the last sequencing cycle, SHALL be dropped with no effect on memory, pointers or cnt.
REQ-021 smpl_out SHALL hold its last value while sequencing=0.
REQ-022 Before the queue first fills, no sequence SHALL occur and sequencing SHALL stay 0.

Reset
REQ-023 On rst_n low, immediately: state=IDLE, new_ptr=old_ptr=rd_ptr=0, cnt=0, sequencing=0, smpl_out=0, ovr=0.
REQ-024 Reset during SEQ SHALL abort the stream at once, and the queue SHALL restart empty.

Configuration
REQ-025 With HP_QUEUE_OVR_EN defined, port ovr SHALL exist; it is set on the edge after any dropped write and cleared only by reset.
REQ-026 Without HP_QUEUE_OVR_EN, port ovr and its logic SHALL be absent, and dropped writes SHALL be silent.

Verification
REQ-027 Fill test: DEPTH=4, write 10,20,30,40 spaced 10 cycles apart -> sequencing stays 0 until 2 cycles after the 4th write, then stays high 4 cycles with smpl_out=10,20,30,40.
REQ-028 Overwrite test: continuing REQ-027, write 50 after the sequence ends -> next stream is 20,30,40,50.
REQ-029 Wrap test: DEPTH=4, 9 spaced writes of 1..9 -> the final stream is 6,7,8,9 and the pointers wrap with no glitch.
REQ-030 Drop test: write 99 in the 2nd sequencing cycle -> stream unaffected, next accepted write 60 gives stream 30,40,50,60, and with HP_QUEUE_OVR_EN ovr=1 from the following cycle.
REQ-031 Reset test: assert rst_n low during the 3rd sequencing cycle -> sequencing=0 and smpl_out=0 immediately; after release, 3 writes produce no stream.
REQ-032 Default test: DEPTH=1021, write a ramp 0..1020 -> exactly 1021 sequencing cycles with smpl_out=0..1020 in order.
